penalty_round_ctrl: RTL and testbench

Round sequencer for solo keeper mode. It runs the aim, flight and result phases of each penalty and latches the keeper's dive zone and the shot zone. It also keeps the save/goal tally and decides when the match ends. It sits between the mouse/click logic and the game-state controller: its `round_done` and `is_scored` outputs drive the KEEPER → WINNER/LOOSER transition.

---
 rtl/penalty_round_ctrl_if.sv | 32 +++
 rtl/penalty_round_ctrl.sv | 176 +++++++++++++++++
 tb/tb_penalty_round_ctrl.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/penalty_round_ctrl_if.sv
// Handshake bundle between the mouse/game-state logic and penalty_round_ctrl.
// master: game side (drives enable, click and zones, observes phases/tallies).
// slave : round sequencer (consumes inputs, drives phases, latched zones, tallies).
interface penalty_round_ctrl_if;
    logic       round_enable;
    logic       keeper_click;
    logic [1:0] keeper_zone;
    logic [1:0] shot_zone;
    logic       aim_phase;
    logic       ball_launch;
    logic       result_phase;
    logic       last_saved;
    logic [1:0] dive_zone;
    logic [1:0] ball_zone;
    logic [2:0] saves;
    logic [2:0] goals;
    logic [2:0] round_counter;
    logic       round_done;
    logic       is_scored;

    modport master (
        output round_enable, keeper_click, keeper_zone, shot_zone,
        input  aim_phase, ball_launch, result_phase, last_saved, dive_zone, ball_zone,
        input  saves, goals, round_counter, round_done, is_scored
    );

    modport slave (
        input  round_enable, keeper_click, keeper_zone, shot_zone,
        output aim_phase, ball_launch, result_phase, last_saved, dive_zone, ball_zone,
        output saves, goals, round_counter, round_done, is_scored
    );
endinterface

// File: rtl/penalty_round_ctrl.sv
// Penalty round sequencer for solo keeper mode.
// Runs AIM -> FLIGHT -> RESULT per penalty, latches dive/shot zones, keeps the
// save/goal tally and pulses round_done (with is_scored) when the match ends.
// Ports:
//   clk   - system clock
//   rst_n - synchronous active-low reset
//   bus   - penalty_round_ctrl_if.slave (enable/click/zones in; phases, zones,
//           tallies, round_done, is_scored out)
module penalty_round_ctrl #(
    parameter int unsigned ROUNDS        = 5,
    parameter int unsigned WIN_SAVES     = 3,
    parameter int unsigned AIM_CYCLES    = 195_000_000,
    parameter int unsigned FLIGHT_CYCLES = 32_500_000,
    parameter int unsigned RESULT_CYCLES = 130_000_000
) (
    input logic                 clk,
    input logic                 rst_n,
    penalty_round_ctrl_if.slave bus
);

    localparam int unsigned GOALS_TO_LOSE = ROUNDS - WIN_SAVES + 1;
    localparam int unsigned MAX_AF        = (AIM_CYCLES > FLIGHT_CYCLES) ? AIM_CYCLES
                                                                         : FLIGHT_CYCLES;
    localparam int unsigned MAX_CYCLES    = (MAX_AF > RESULT_CYCLES) ? MAX_AF : RESULT_CYCLES;
    localparam int unsigned TW            = $clog2(MAX_CYCLES);

    typedef logic [TW-1:0] timer_t;

    localparam timer_t AIM_LOAD    = timer_t'(AIM_CYCLES - 1);
    localparam timer_t FLIGHT_LOAD = timer_t'(FLIGHT_CYCLES - 1);
    localparam timer_t RESULT_LOAD = timer_t'(RESULT_CYCLES - 1);

    typedef enum logic [2:0] {StIdle, StAim, StFlight, StResult, StDone} state_e;

    state_e     state_q, state_d;
    timer_t     timer_q, timer_d;
    logic [2:0] saves_q, saves_d;
    logic [2:0] goals_q, goals_d;
    logic [2:0] round_q, round_d;
    logic [1:0] dive_q, dive_d;
    logic [1:0] ball_q, ball_d;
    logic       last_saved_q, last_saved_d;
    logic       is_scored_q, is_scored_d;
    logic       round_done_q, round_done_d;

    logic       timer_zero;
    logic       valid_click;
    logic [1:0] shot_norm;
    logic       round_saved;
    logic       match_over;

    assign timer_zero  = (timer_q == '0);
    assign valid_click = bus.keeper_click && (bus.keeper_zone != 2'd3);
    // Zone 3 from the random source folds onto the centre.
    assign shot_norm   = (bus.shot_zone == 2'd3) ? 2'd1 : bus.shot_zone;
    assign round_saved = (dive_q == ball_q);
    assign match_over  = (saves_q == 3'(WIN_SAVES)) || (goals_q == 3'(GOALS_TO_LOSE)) ||
                         (round_q == 3'(ROUNDS));

    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        saves_d      = saves_q;
        goals_d      = goals_q;
        round_d      = round_q;
        dive_d       = dive_q;
        ball_d       = ball_q;
        last_saved_d = last_saved_q;
        is_scored_d  = is_scored_q;
        round_done_d = 1'b0;

        case (state_q)
            StIdle: begin
                state_d = StAim;
                timer_d = AIM_LOAD;
            end
            StAim: begin
                // A valid click beats the timeout when both land on the same cycle.
                if (valid_click) begin
                    dive_d  = bus.keeper_zone;
                    ball_d  = shot_norm;
                    state_d = StFlight;
                    timer_d = FLIGHT_LOAD;
                end else if (timer_zero) begin
                    dive_d  = 2'd3;
                    ball_d  = shot_norm;
                    state_d = StFlight;
                    timer_d = FLIGHT_LOAD;
                end else begin
                    timer_d = timer_q - timer_t'(1);
                end
            end
            StFlight: begin
                if (timer_zero) begin
                    if (round_saved) saves_d = saves_q + 3'd1;
                    else             goals_d = goals_q + 3'd1;
                    round_d      = round_q + 3'd1;
                    last_saved_d = round_saved;
                    state_d      = StResult;
                    timer_d      = RESULT_LOAD;
                end else begin
                    timer_d = timer_q - timer_t'(1);
                end
            end
            StResult: begin
                if (timer_zero) begin
                    if (match_over) begin
                        state_d      = StDone;
                        round_done_d = 1'b1;
                        is_scored_d  = (saves_q < 3'(WIN_SAVES));
                    end else begin
                        state_d = StAim;
                        timer_d = AIM_LOAD;
                    end
                end else begin
                    timer_d = timer_q - timer_t'(1);
                end
            end
            StDone: ;
            default: state_d = StIdle;
        endcase

        // Leaving KEEPER/SOLO aborts everything and wipes the match.
        if (!bus.round_enable) begin
            state_d      = StIdle;
            timer_d      = '0;
            saves_d      = '0;
            goals_d      = '0;
            round_d      = '0;
            dive_d       = '0;
            ball_d       = '0;
            last_saved_d = 1'b0;
            is_scored_d  = 1'b0;
            round_done_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            timer_q      <= '0;
            saves_q      <= '0;
            goals_q      <= '0;
            round_q      <= '0;
            dive_q       <= '0;
            ball_q       <= '0;
            last_saved_q <= 1'b0;
            is_scored_q  <= 1'b0;
            round_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            saves_q      <= saves_d;
            goals_q      <= goals_d;
            round_q      <= round_d;
            dive_q       <= dive_d;
            ball_q       <= ball_d;
            last_saved_q <= last_saved_d;
            is_scored_q  <= is_scored_d;
            round_done_q <= round_done_d;
        end
    end

    assign bus.aim_phase     = (state_q == StAim);
    assign bus.ball_launch   = (state_q == StFlight) && (timer_q == FLIGHT_LOAD);
    assign bus.result_phase  = (state_q == StResult);
    assign bus.last_saved    = last_saved_q;
    assign bus.dive_zone     = dive_q;
    assign bus.ball_zone     = ball_q;
    assign bus.saves         = saves_q;
    assign bus.goals         = goals_q;
    assign bus.round_counter = round_q;
    assign bus.round_done    = round_done_q;
    assign bus.is_scored     = is_scored_q;

endmodule

// File: tb/tb_penalty_round_ctrl.sv
// Scoreboard bench for penalty_round_ctrl: the driver pushes the expected
// per-round result and match end; a negedge monitor pops and compares.
module tb_penalty_round_ctrl;

    localparam int AIM = 8;
    localparam int FLT = 4;
    localparam int RES = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    penalty_round_ctrl_if bus ();

    penalty_round_ctrl #(
        .ROUNDS        (5),
        .WIN_SAVES     (3),
        .AIM_CYCLES    (AIM),
        .FLIGHT_CYCLES (FLT),
        .RESULT_CYCLES (RES)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int dive;
        int ball;
        int saved;
        int saves;
        int goals;
        int rounds;
        int aim_len;
    } round_exp_t;

    typedef struct {
        int scored;
        int saves;
        int goals;
        int rounds;
    } done_exp_t;

    round_exp_t rq[$];
    done_exp_t  dq[$];

    int checks = 0;
    int errors = 0;
    int m_saves, m_goals, m_rounds;

    task automatic check_val(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Monitor state
    logic       prev_aim = 1'b0, prev_res = 1'b0, prev_done = 1'b0;
    int         aim_cnt = 0, flight_cnt = 0, launch_cnt = 0, res_cnt = 0;
    round_exp_t mr;
    done_exp_t  md;

    always @(negedge clk) begin
        if (bus.aim_phase && !prev_aim) begin
            aim_cnt    = 1;
            flight_cnt = 0;
            launch_cnt = 0;
        end else if (bus.aim_phase) begin
            aim_cnt++;
        end
        if (!bus.aim_phase && !bus.result_phase && prev_aim) flight_cnt = 0;
        if (!bus.aim_phase && !bus.result_phase && (prev_aim || flight_cnt > 0)) flight_cnt++;
        if (bus.ball_launch) launch_cnt++;

        if (bus.result_phase && !prev_res) begin
            res_cnt = 1;
            if (rq.size() == 0) begin
                check_val("unexpected_result", 0, 1);
            end else begin
                mr = rq.pop_front();
                check_val("dive_zone", int'(bus.dive_zone), mr.dive);
                check_val("ball_zone", int'(bus.ball_zone), mr.ball);
                check_val("last_saved", int'(bus.last_saved), mr.saved);
                check_val("saves", int'(bus.saves), mr.saves);
                check_val("goals", int'(bus.goals), mr.goals);
                check_val("round_counter", int'(bus.round_counter), mr.rounds);
                check_val("aim_len", aim_cnt, mr.aim_len);
                check_val("flight_len", flight_cnt, FLT);
                check_val("launch_pulses", launch_cnt, 1);
            end
            flight_cnt = 0;
        end else if (bus.result_phase) begin
            res_cnt++;
        end
        if (!bus.result_phase && prev_res) check_val("result_len", res_cnt, RES);

        if (prev_done) check_val("done_one_cycle", int'(bus.round_done), 0);
        if (bus.round_done) begin
            if (dq.size() == 0) begin
                check_val("unexpected_done", 0, 1);
            end else begin
                md = dq.pop_front();
                check_val("is_scored", int'(bus.is_scored), md.scored);
                check_val("done_saves", int'(bus.saves), md.saves);
                check_val("done_goals", int'(bus.goals), md.goals);
                check_val("done_rounds", int'(bus.round_counter), md.rounds);
            end
        end

        prev_aim  = bus.aim_phase;
        prev_res  = bus.result_phase;
        prev_done = bus.round_done;
    end

    task automatic model_clear();
        m_saves  = 0;
        m_goals  = 0;
        m_rounds = 0;
    endtask

    task automatic check_idle(input string tag);
        logic [18:0] v;
        v = {bus.aim_phase, bus.ball_launch, bus.result_phase, bus.last_saved, bus.dive_zone,
             bus.ball_zone, bus.saves, bus.goals, bus.round_counter, bus.round_done,
             bus.is_scored};
        check_val(tag, int'(v), 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Enable from IDLE; returns #1 after the edge that enters the first AIM cycle.
    task automatic start_match();
        bit seen;
        seen = 1'b0;
        bus.round_enable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.aim_phase) begin
                seen = 1'b1;
                break;
            end
        end
        check_val("start_aim", int'(seen), 1);
    endtask

    task automatic drop_enable(input string tag);
        bus.round_enable = 1'b0;
        tick();
        check_idle(tag);
        model_clear();
    endtask

    // Starts in the first AIM cycle; click_at < 0 means no click at all.
    task automatic play_round(input int click_at, input logic [1:0] kz, input logic [1:0] sz);
        round_exp_t e;
        done_exp_t  d;
        bit         valid;
        bit         fin;
        valid     = (click_at >= 0) && (click_at < AIM) && (kz != 2'd3);
        e.dive    = valid ? int'(kz) : 3;
        e.ball    = (sz == 2'd3) ? 1 : int'(sz);
        e.saved   = (e.dive == e.ball) ? 1 : 0;
        m_saves  += e.saved;
        m_goals  += 1 - e.saved;
        m_rounds += 1;
        e.saves   = m_saves;
        e.goals   = m_goals;
        e.rounds  = m_rounds;
        e.aim_len = valid ? click_at + 1 : AIM;
        rq.push_back(e);
        if (m_saves == 3 || m_goals == 3 || m_rounds == 5) begin
            d.scored = (m_saves < 3) ? 1 : 0;
            d.saves  = m_saves;
            d.goals  = m_goals;
            d.rounds = m_rounds;
            dq.push_back(d);
        end

        bus.shot_zone = sz;
        for (int c = 0; c < AIM + 2; c++) begin
            bus.keeper_click = (c == click_at);
            bus.keeper_zone  = (c == click_at) ? kz : 2'd3;
            tick();
            if (!bus.aim_phase) break;
        end
        bus.keeper_click = 1'b0;
        bus.keeper_zone  = 2'd3;

        fin = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (bus.aim_phase || bus.round_done) begin
                fin = 1'b1;
                break;
            end
        end
        check_val("round_progress", int'(fin), 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n            = 1'b0;
        bus.round_enable = 1'b0;
        bus.keeper_click = 1'b0;
        bus.keeper_zone  = 2'd3;
        bus.shot_zone    = 2'd0;
        model_clear();
        tick();
        tick();
        check_idle("reset_idle");
        rst_n = 1'b1;
        tick();
        check_idle("idle_disabled");

        // Three saves
        start_match();
        for (int r = 0; r < 3; r++) play_round(2, 2'd0, 2'd0);
        drop_enable("after_three_saves");

        // Three timeouts
        start_match();
        for (int r = 0; r < 3; r++) play_round(-1, 2'd0, 2'd2);
        drop_enable("after_three_timeouts");

        // Full match: save, goal, save, goal, save
        start_match();
        play_round(1, 2'd0, 2'd0);
        play_round(1, 2'd0, 2'd1);
        play_round(1, 2'd2, 2'd2);
        play_round(1, 2'd1, 2'd0);
        play_round(3, 2'd1, 2'd1);
        drop_enable("after_full_match");

        // Click edge cases: click on timeout cycle, zone-3 click, shot 3
        start_match();
        play_round(AIM - 1, 2'd2, 2'd2);
        play_round(0, 2'd3, 2'd0);
        play_round(2, 2'd1, 2'd3);
        drop_enable("after_edge_cases");

        // Abort in FLIGHT of round 2
        start_match();
        play_round(1, 2'd0, 2'd0);
        bus.shot_zone    = 2'd0;
        bus.keeper_zone  = 2'd0;
        bus.keeper_click = 1'b1;
        tick();
        bus.keeper_click = 1'b0;
        bus.keeper_zone  = 2'd3;
        check_val("click_launch", int'(bus.ball_launch), 1);
        tick();
        drop_enable("abort_idle");
        start_match();
        check_val("reenable_round", int'(bus.round_counter), 0);
        drop_enable("after_abort");

        // Synchronous reset mid-AIM with two saves
        start_match();
        play_round(0, 2'd1, 2'd1);
        play_round(0, 2'd1, 2'd1);
        tick();
        check_val("pre_reset_saves", int'(bus.saves), 2);
        rst_n = 1'b0;
        tick();
        check_idle("reset_mid_aim");
        rst_n = 1'b1;
        model_clear();
        tick();
        check_val("reentry_aim", int'(bus.aim_phase), 1);
        drop_enable("final_idle");

        tick();
        check_val("round_queue_empty", rq.size(), 0);
        check_val("done_queue_empty", dq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
